axi4_stream_router: RTL and testbench

AXI4_STREAM_ROUTER -- requirements
Module: axi4_stream_router

---
 rtl/axi4s_pkg.sv | 18 +
 rtl/axi4s_keep_pack.sv | 21 ++
 rtl/axi4_stream_router.sv | 133 +++++++++++++
 tb/tb_axi4_stream_router.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4s_pkg.sv
// Shared types and width helpers for the AXI4-Stream router.
package axi4s_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } rtr_state_e;

  // Stored FIFO word: {tlast, keep flags, tdata}.
  function automatic int unsigned fifo_width(input int unsigned data_bytes,
                                             input int unsigned keep_grp);
    return 8 * data_bytes + data_bytes / keep_grp + 1;
  endfunction

  localparam int unsigned FIFO_W_DEFAULT = fifo_width(16, 4);

endpackage

// File: rtl/axi4s_keep_pack.sv
// Compresses byte-level tkeep to one flag per KEEP_GRP-byte group (lowest byte of each group).
module axi4s_keep_pack #(
  parameter int unsigned DATA_BYTES = 16,
  parameter int unsigned KEEP_GRP   = 4
) (
  input  logic [DATA_BYTES-1:0]          tkeep,
  output logic [DATA_BYTES/KEEP_GRP-1:0] flags
);

  localparam int unsigned NGRP = DATA_BYTES / KEEP_GRP;

  logic unused_keep;

  for (genvar g = 0; g < NGRP; g++) begin : g_flag
    assign flags[g] = tkeep[g*KEEP_GRP];
  end

  // Upstream keeps whole groups; the other bytes of each group carry no extra information.
  assign unused_keep = ^tkeep;

endmodule

// File: rtl/axi4_stream_router.sv
// Routes AXI4-Stream packets by tdest into per-channel FIFOs; out-of-range tdest is dropped.
module axi4_stream_router
  import axi4s_pkg::*;
#(
  parameter  int unsigned DATA_BYTES = 16,
  parameter  int unsigned TDEST_W    = 2,
  parameter  int unsigned NUM_CH     = 3,
  parameter  int unsigned KEEP_GRP   = 4,
  parameter  int unsigned CNT_W      = 16,
  localparam int unsigned FIFO_W     = fifo_width(DATA_BYTES, KEEP_GRP)
) (
  input  logic                    clk,
  input  logic                    reset_n,

  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [8*DATA_BYTES-1:0] s_axis_tdata,
  input  logic [DATA_BYTES-1:0]   s_axis_tkeep,
  input  logic                    s_axis_tlast,
  input  logic [TDEST_W-1:0]      s_axis_tdest,

  output logic [FIFO_W-1:0]       fifo_wr_data,
  output logic [NUM_CH-1:0]       fifo_wr_en,
  input  logic [NUM_CH-1:0]       fifo_prog_full,
  input  logic [NUM_CH-1:0]       fifo_full,

  output logic [CNT_W-1:0]        pkt_cnt,
  output logic [CNT_W-1:0]        drop_cnt,
  output logic                    ovf_err,
  input  logic                    err_clr
);

  localparam int unsigned FLAG_W     = DATA_BYTES / KEEP_GRP;
  localparam int unsigned CH_SPACE   = 1 << TDEST_W;
  localparam int unsigned DEST_CMP_W = TDEST_W + 1;

  rtr_state_e          state;
  logic [TDEST_W-1:0]  ch;
  logic [CH_SPACE-1:0] prog_full_ext;
  logic [CH_SPACE-1:0] full_ext;
  logic [CH_SPACE-1:0] ch_onehot;
  logic [FLAG_W-1:0]   flags;
  logic                dest_ok;
  logic                beat_acc;
  logic                pass_acc;
  logic                drop_acc;

  // Status vectors widened to the full tdest space so ch can index them directly.
  assign prog_full_ext = CH_SPACE'(fifo_prog_full);
  assign full_ext      = CH_SPACE'(fifo_full);
  assign ch_onehot     = CH_SPACE'(1) << ch;

  assign dest_ok = DEST_CMP_W'(s_axis_tdest) < DEST_CMP_W'(NUM_CH);

  always_comb begin
    s_axis_tready = 1'b0;
    unique case (state)
      PASS:    s_axis_tready = ~prog_full_ext[ch];
      DROP:    s_axis_tready = 1'b1;
      default: s_axis_tready = 1'b0;
    endcase
  end

  assign beat_acc = s_axis_tvalid & s_axis_tready;
  assign pass_acc = beat_acc & (state == PASS);
  assign drop_acc = beat_acc & (state == DROP);

  axi4s_keep_pack #(
    .DATA_BYTES (DATA_BYTES),
    .KEEP_GRP   (KEEP_GRP)
  ) u_keep_pack (
    .tkeep (s_axis_tkeep),
    .flags (flags)
  );

  // Packet-level FSM; the header beat is only inspected in IDLE, never consumed there.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      ch    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (s_axis_tvalid) begin
            ch    <= s_axis_tdest;
            state <= dest_ok ? PASS : DROP;
          end
        end
        PASS, DROP: begin
          if (beat_acc && s_axis_tlast) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write port: strobe only for the cycle after an accepted PASS beat, data holds otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_wr_en   <= '0;
      fifo_wr_data <= '0;
    end else begin
      fifo_wr_en <= '0;
      if (pass_acc) begin
        fifo_wr_en   <= NUM_CH'(ch_onehot);
        fifo_wr_data <= {s_axis_tlast, flags, s_axis_tdata};
      end
    end
  end

  // Forwarded count wraps; drop count saturates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (pass_acc && s_axis_tlast) pkt_cnt <= pkt_cnt + CNT_W'(1);
      if (drop_acc && s_axis_tlast && !(&drop_cnt)) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  // Sticky overflow flag; a new overflow in the clear cycle keeps it set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_err <= 1'b0;
    end else if (pass_acc && full_ext[ch]) begin
      ovf_err <= 1'b1;
    end else if (err_clr) begin
      ovf_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi4_stream_router.sv
// Scoreboard bench for axi4_stream_router: expected FIFO writes queued at beat acceptance.
module tb_axi4_stream_router;
  import axi4s_pkg::*;

  localparam int unsigned DB  = 16;
  localparam int unsigned TW  = 2;
  localparam int unsigned NCH = 3;
  localparam int unsigned KG  = 4;
  localparam int unsigned CW  = 16;
  localparam int unsigned FW  = fifo_width(DB, KG);
  localparam int unsigned SBW = NCH + FW;

  logic            clk;
  logic            reset_n;
  logic            s_axis_tvalid;
  logic            s_axis_tready;
  logic [8*DB-1:0] s_axis_tdata;
  logic [DB-1:0]   s_axis_tkeep;
  logic            s_axis_tlast;
  logic [TW-1:0]   s_axis_tdest;
  logic [FW-1:0]   fifo_wr_data;
  logic [NCH-1:0]  fifo_wr_en;
  logic [NCH-1:0]  fifo_prog_full;
  logic [NCH-1:0]  fifo_full;
  logic [CW-1:0]   pkt_cnt;
  logic [CW-1:0]   drop_cnt;
  logic            ovf_err;
  logic            err_clr;

  logic            sat_tready;
  logic [FW-1:0]   sat_wr_data;
  logic [NCH-1:0]  sat_wr_en;
  logic [3:0]      sat_pkt_cnt;
  logic [3:0]      sat_drop_cnt;
  logic            sat_ovf_err;

  logic [SBW-1:0]  sb[$];
  logic [SBW-1:0]  exp_w;
  int              checks;
  int              passes;
  int              wr_count;

  axi4_stream_router dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tkeep   (s_axis_tkeep),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tdest   (s_axis_tdest),
    .fifo_wr_data   (fifo_wr_data),
    .fifo_wr_en     (fifo_wr_en),
    .fifo_prog_full (fifo_prog_full),
    .fifo_full      (fifo_full),
    .pkt_cnt        (pkt_cnt),
    .drop_cnt       (drop_cnt),
    .ovf_err        (ovf_err),
    .err_clr        (err_clr)
  );

  // Narrow-counter copy watching the same stream to reach drop_cnt saturation quickly.
  axi4_stream_router #(.CNT_W(4)) sat_dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (sat_tready),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tkeep   (s_axis_tkeep),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tdest   (s_axis_tdest),
    .fifo_wr_data   (sat_wr_data),
    .fifo_wr_en     (sat_wr_en),
    .fifo_prog_full (fifo_prog_full),
    .fifo_full      (fifo_full),
    .pkt_cnt        (sat_pkt_cnt),
    .drop_cnt       (sat_drop_cnt),
    .ovf_err        (sat_ovf_err),
    .err_clr        (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1);
  end

  function automatic logic [DB/KG-1:0] pack_flags(input logic [DB-1:0] k);
    logic [DB/KG-1:0] f;
    for (int i = 0; i < DB/KG; i++) f[i] = k[i*KG];
    return f;
  endfunction

  function automatic logic [SBW-1:0] exp_word(input logic [TW-1:0] ch, input logic l,
                                              input logic [DB-1:0] k, input logic [8*DB-1:0] d);
    logic [NCH-1:0] en;
    en = NCH'(1) << ch;
    return {en, l, pack_flags(k), d};
  endfunction

  // Every write strobe is checked against the oldest expected write.
  always @(negedge clk) begin
    if (reset_n && fifo_wr_en !== '0) begin
      wr_count++;
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL wr_unexpected: got en=%b data=%h, required no write", fifo_wr_en, fifo_wr_data);
      end else begin
        exp_w = sb.pop_front();
        if ({fifo_wr_en, fifo_wr_data} !== exp_w)
          $display("FAIL wr_word: got %h, required %h", {fifo_wr_en, fifo_wr_data}, exp_w);
        else
          passes++;
      end
    end
  end

  task automatic send_beat(input logic [8*DB-1:0] d, input logic [DB-1:0] k, input logic l,
                           input logic [TW-1:0] dest, input logic exp_pass,
                           input logic [TW-1:0] exp_ch, output int n);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tdest  = dest;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_axis_tready && n < 40);
    if (!s_axis_tready) begin
      checks++;
      $display("FAIL beat_timeout: tready=%b after %0d cycles, required 1", s_axis_tready, n);
    end else if (exp_pass) begin
      sb.push_back(exp_word(exp_ch, l, k, d));
    end
    @(posedge clk);
    #1;
  endtask

  // tdest is flipped after the header beat; the router must ignore it.
  task automatic send_pkt(input logic [TW-1:0] dest, input int nbeats, input logic [DB-1:0] last_keep,
                          input logic exp_pass, output int wait_sum);
    logic [8*DB-1:0] d;
    int n;
    wait_sum = 0;
    for (int b = 0; b < nbeats; b++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      send_beat(d, (b == nbeats-1) ? last_keep : 16'hFFFF, b == nbeats-1,
                (b == 0) ? dest : ~dest, exp_pass, dest, n);
      wait_sum += n;
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic idle(input int ncyc);
    s_axis_tvalid = 1'b0;
    repeat (ncyc) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks += 6;
    if (s_axis_tready !== 1'b0) $display("FAIL rst_tready: got %b, required 0", s_axis_tready); else passes++;
    if (fifo_wr_en !== '0) $display("FAIL rst_wr_en: got %b, required 0", fifo_wr_en); else passes++;
    if (fifo_wr_data !== '0) $display("FAIL rst_wr_data: got %h, required 0", fifo_wr_data); else passes++;
    if (pkt_cnt !== '0) $display("FAIL rst_pkt_cnt: got %0d, required 0", pkt_cnt); else passes++;
    if (drop_cnt !== '0) $display("FAIL rst_drop_cnt: got %0d, required 0", drop_cnt); else passes++;
    if (ovf_err !== 1'b0) $display("FAIL rst_ovf_err: got %b, required 0", ovf_err); else passes++;
    @(negedge clk);
    reset_n = 1'b1;
    idle(2);
  endtask

  task automatic test_pass_basic();
    int wc0, ws;
    wc0 = wr_count;
    send_pkt(2'd1, 4, 16'h00FF, 1'b1, ws);
    idle(3);
    checks += 5;
    if (wr_count - wc0 !== 4) $display("FAIL pass_writes: got %0d, required 4", wr_count - wc0); else passes++;
    if (pkt_cnt !== 16'd1) $display("FAIL pass_pkt_cnt: got %0d, required 1", pkt_cnt); else passes++;
    if (fifo_wr_data[FW-1] !== 1'b1) $display("FAIL pass_tlast_bit: got %b, required 1", fifo_wr_data[FW-1]); else passes++;
    if (fifo_wr_data[FW-2 -: 4] !== 4'b0011)
      $display("FAIL pass_flags: got %b, required 0011", fifo_wr_data[FW-2 -: 4]);
    else passes++;
    if (sb.size() != 0) $display("FAIL pass_sb_empty: got %0d pending, required 0", sb.size()); else passes++;
  endtask

  task automatic test_drop();
    int wc0, ws;
    wc0 = wr_count;
    send_pkt(2'd3, 5, 16'hFFFF, 1'b0, ws);
    idle(3);
    checks += 4;
    if (ws !== 6) $display("FAIL drop_ready_cycles: got %0d, required 6", ws); else passes++;
    if (wr_count !== wc0) $display("FAIL drop_writes: got %0d, required 0", wr_count - wc0); else passes++;
    if (drop_cnt !== 16'd1) $display("FAIL drop_cnt: got %0d, required 1", drop_cnt); else passes++;
    if (pkt_cnt !== 16'd1) $display("FAIL drop_pkt_cnt: got %0d, required 1", pkt_cnt); else passes++;
  endtask

  task automatic test_prog_full();
    int wc0, wc1, n;
    logic [8*DB-1:0] d;
    wc0 = wr_count;
    wc1 = 0;
    send_beat({4{$urandom}}, 16'($urandom), 1'b0, 2'd0, 1'b1, 2'd0, n);
    fifo_prog_full = 3'b001;
    d = {$urandom, $urandom, $urandom, $urandom};
    s_axis_tdata   = d;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (s_axis_tready !== 1'b0) $display("FAIL pf_stall_%0d: tready=%b, required 0", i, s_axis_tready); else passes++;
      if (i == 1) wc1 = wr_count;
    end
    @(posedge clk);
    #1;
    checks++;
    if (wr_count !== wc1) $display("FAIL pf_no_write: got %0d writes, required 0", wr_count - wc1); else passes++;
    fifo_prog_full = 3'b000;
    send_beat(d, 16'($urandom), 1'b0, 2'd1, 1'b1, 2'd0, n);
    send_beat({4{$urandom}}, 16'($urandom), 1'b0, 2'd2, 1'b1, 2'd0, n);
    send_beat({4{$urandom}}, 16'h0F0F, 1'b1, 2'd3, 1'b1, 2'd0, n);
    idle(3);
    checks += 3;
    if (wr_count - wc0 !== 4) $display("FAIL pf_writes: got %0d, required 4", wr_count - wc0); else passes++;
    if (pkt_cnt !== 16'd2) $display("FAIL pf_pkt_cnt: got %0d, required 2", pkt_cnt); else passes++;
    if (sb.size() != 0) $display("FAIL pf_sb_empty: got %0d pending, required 0", sb.size()); else passes++;
  endtask

  task automatic test_ovf();
    int ws;
    checks++;
    if (ovf_err !== 1'b0) $display("FAIL ovf_initial: got %b, required 0", ovf_err); else passes++;
    fifo_full = 3'b001;
    send_pkt(2'd1, 1, 16'hFFFF, 1'b1, ws);
    checks++;
    if (ovf_err !== 1'b0) $display("FAIL ovf_other_ch: got %b, required 0", ovf_err); else passes++;
    fifo_full = 3'b100;
    send_pkt(2'd2, 1, 16'hFFFF, 1'b1, ws);
    fifo_full = 3'b000;
    checks++;
    if (ovf_err !== 1'b1) $display("FAIL ovf_set: got %b, required 1", ovf_err); else passes++;
    idle(3);
    checks++;
    if (ovf_err !== 1'b1) $display("FAIL ovf_sticky: got %b, required 1", ovf_err); else passes++;
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    checks++;
    if (ovf_err !== 1'b0) $display("FAIL ovf_clear: got %b, required 0", ovf_err); else passes++;
    fifo_full = 3'b100;
    err_clr   = 1'b1;
    send_pkt(2'd2, 1, 16'hFFFF, 1'b1, ws);
    err_clr   = 1'b0;
    fifo_full = 3'b000;
    idle(1);
    checks++;
    if (ovf_err !== 1'b1) $display("FAIL ovf_set_wins: got %b, required 1", ovf_err); else passes++;
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    idle(2);
    checks += 2;
    if (ovf_err !== 1'b0) $display("FAIL ovf_clear2: got %b, required 0", ovf_err); else passes++;
    if (sb.size() != 0) $display("FAIL ovf_sb_empty: got %0d pending, required 0", sb.size()); else passes++;
  endtask

  task automatic test_back_to_back();
    int lens[3]  = '{1, 2, 1};
    int dests[3] = '{2, 0, 1};
    int n;
    logic [CW-1:0] p0;
    p0 = pkt_cnt;
    for (int p = 0; p < 3; p++) begin
      for (int b = 0; b < lens[p]; b++) begin
        send_beat({4{$urandom}}, 16'($urandom), b == lens[p]-1, TW'(dests[p]), 1'b1, TW'(dests[p]), n);
        checks++;
        if (n !== ((b == 0) ? 2 : 1))
          $display("FAIL b2b_wait_p%0d_b%0d: got %0d cycles, required %0d", p, b, n, (b == 0) ? 2 : 1);
        else passes++;
      end
    end
    idle(3);
    checks += 2;
    if (pkt_cnt - p0 !== CW'(3)) $display("FAIL b2b_pkt_cnt: got +%0d, required +3", pkt_cnt - p0); else passes++;
    if (sb.size() != 0) $display("FAIL b2b_sb_empty: got %0d pending, required 0", sb.size()); else passes++;
  endtask

  task automatic test_reset_mid();
    int n;
    send_beat({4{$urandom}}, 16'hFFFF, 1'b0, 2'd1, 1'b1, 2'd1, n);
    send_beat({4{$urandom}}, 16'hFFFF, 1'b0, 2'd1, 1'b1, 2'd1, n);
    @(negedge clk);
    #1;
    reset_n       = 1'b0;
    s_axis_tvalid = 1'b0;
    #1;
    checks += 6;
    if (s_axis_tready !== 1'b0) $display("FAIL rm_tready: got %b, required 0", s_axis_tready); else passes++;
    if (fifo_wr_en !== '0) $display("FAIL rm_wr_en: got %b, required 0", fifo_wr_en); else passes++;
    if (fifo_wr_data !== '0) $display("FAIL rm_wr_data: got %h, required 0", fifo_wr_data); else passes++;
    if (pkt_cnt !== '0) $display("FAIL rm_pkt_cnt: got %0d, required 0", pkt_cnt); else passes++;
    if (drop_cnt !== '0) $display("FAIL rm_drop_cnt: got %0d, required 0", drop_cnt); else passes++;
    if (ovf_err !== 1'b0) $display("FAIL rm_ovf_err: got %b, required 0", ovf_err); else passes++;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(1);
    send_beat({4{$urandom}}, 16'h000F, 1'b1, 2'd2, 1'b1, 2'd2, n);
    s_axis_tvalid = 1'b0;
    checks++;
    if (n !== 2) $display("FAIL rm_bubble: got %0d cycles, required 2", n); else passes++;
    idle(3);
    checks += 2;
    if (pkt_cnt !== 16'd1) $display("FAIL rm_pkt_cnt_after: got %0d, required 1", pkt_cnt); else passes++;
    if (sb.size() != 0) $display("FAIL rm_sb_empty: got %0d pending, required 0", sb.size()); else passes++;
  endtask

  task automatic test_drop_sat();
    int ws;
    for (int i = 0; i < 17; i++) begin
      send_pkt(2'd3, 1, 16'hFFFF, 1'b0, ws);
      if (i == 14) begin
        idle(1);
        checks++;
        if (sat_drop_cnt !== 4'hF) $display("FAIL sat_reach: got %0d, required 15", sat_drop_cnt); else passes++;
      end
    end
    idle(2);
    checks += 2;
    if (sat_drop_cnt !== 4'hF) $display("FAIL sat_hold: got %0d, required 15", sat_drop_cnt); else passes++;
    if (drop_cnt !== 16'd17) $display("FAIL sat_wide_cnt: got %0d, required 17", drop_cnt); else passes++;
  endtask

  initial begin
    checks         = 0;
    passes         = 0;
    wr_count       = 0;
    reset_n        = 1'b0;
    s_axis_tvalid  = 1'b0;
    s_axis_tdata   = '0;
    s_axis_tkeep   = '0;
    s_axis_tlast   = 1'b0;
    s_axis_tdest   = '0;
    fifo_prog_full = '0;
    fifo_full      = '0;
    err_clr        = 1'b0;
    test_reset();
    test_pass_basic();
    test_drop();
    test_prog_full();
    test_ovf();
    test_back_to_back();
    test_reset_mid();
    test_drop_sat();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
